// File: rtl/fcmp_pipe.sv
// fcmp_pipe - two-stage pipelined IEEE-754 single-precision predicate/compare unit.
//
// Evaluates iszero/ispos/isneg on x and eq/lt/le on (x, y) using raw-bit
// sign-magnitude rules (no NaN or denormal special cases, no exception flags).
// A 1-bit result and the destination tag are returned two edges after accept.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous reset, active HIGH despite the name
//   flush      synchronous flush, drops both pipeline stages
//   in_valid   operation offered           in_ready   unit can accept this cycle
//   in_op      0 iszero, 1 ispos, 2 isneg, 3 eq, 4 lt, 5 le, 6-7 illegal
//   in_x/in_y  operands (in_y unused by predicates)
//   in_tag     destination tag
//   out_valid  result held for consumer    out_ready  consumer accepts this cycle
//   out_y      result bit                  out_err    op was illegal
//   out_tag    tag of the result
module fcmp_pipe #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ISZERO = 3'd0;
  localparam logic [2:0] OP_ISPOS  = 3'd1;
  localparam logic [2:0] OP_ISNEG  = 3'd2;
  localparam logic [2:0] OP_EQ     = 3'd3;
  localparam logic [2:0] OP_LT     = 3'd4;
  localparam logic [2:0] OP_LE     = 3'd5;

  // Stage 1 registers
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [31:0]      s1_x;
  logic [31:0]      s1_y;
  logic [TAG_W-1:0] s1_tag;

  logic s1_adv;
  logic s2_adv;

  // S2 may take a new value whenever it is empty or being drained; S1 may
  // take a new op whenever it is empty or can hand its op to S2.  Neither
  // term looks at in_valid, so there is no combinational in_valid->in_ready path.
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    if (rstn) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_x   <= in_x;
        s1_y   <= in_y;
        s1_tag <= in_tag;
      end
    end
  end

  // Compare helpers on raw sign-magnitude bits
  logic both_zero;
  logic mag_lt;
  logic mag_gt;
  logic cmp_eq;
  logic cmp_lt;

  assign both_zero = (s1_x[30:0] == 31'd0) && (s1_y[30:0] == 31'd0);
  assign mag_lt    = s1_x[30:0] < s1_y[30:0];
  assign mag_gt    = s1_x[30:0] > s1_y[30:0];
  // +0 and -0 compare equal; everything else is plain bit equality.
  assign cmp_eq    = (s1_x == s1_y) || both_zero;

  always_comb begin
    // NOTE: every branch of a combinational block must assign the output;
    // assigning a default first guarantees no latch is inferred.
    cmp_lt = 1'b0;
    if (both_zero) begin
      cmp_lt = 1'b0;
    end else if (s1_x[31] != s1_y[31]) begin
      cmp_lt = s1_x[31];
    end else if (!s1_x[31]) begin
      cmp_lt = mag_lt;
    end else begin
      // Both negative: larger magnitude is the smaller number.
      cmp_lt = mag_gt;
    end
  end

  logic res_y;
  logic res_err;

  always_comb begin
    res_y   = 1'b0;
    res_err = 1'b0;
    case (s1_op)
      OP_ISZERO: res_y = (s1_x == 32'h0000_0000);
      OP_ISPOS:  res_y = ~s1_x[31];
      OP_ISNEG:  res_y = s1_x[31];
      OP_EQ:     res_y = cmp_eq;
      OP_LT:     res_y = cmp_lt;
      OP_LE:     res_y = cmp_lt | cmp_eq;
      default:   res_err = 1'b1;
    endcase
  end

  // Stage 2: result registers; held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y   <= res_y;
        out_err <= res_err;
        out_tag <= s1_tag;
      end
    end
  end

endmodule
